// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB PID encodings, state codes and payload limit
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [6:0] MAX_BYTES_DEFAULT = 7'd64;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE          = 4'd0;
  localparam state_t S_WAIT_OUT_TOK  = 4'd1;
  localparam state_t S_WAIT_DATA     = 4'd2;
  localparam state_t S_RX_DATA       = 4'd3;
  localparam state_t S_SEND_ACK      = 4'd4;
  localparam state_t S_WAIT_TX_HS    = 4'd5;
  localparam state_t S_WAIT_IN_TOK   = 4'd6;
  localparam state_t S_SEND_NAK      = 4'd7;
  localparam state_t S_WAIT_NAK_TX   = 4'd8;
  localparam state_t S_SEND_DATA     = 4'd9;
  localparam state_t S_WAIT_DATA_TX  = 4'd10;
  localparam state_t S_WAIT_HOST_ACK = 4'd11;
  localparam state_t S_ERR           = 4'd12;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// rtl/usb_txn_ctrl_if.sv - RX/TX/buffer/status signal bundle around the transaction sequencer
interface usb_txn_ctrl_if;

  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [6:0] buffer_occupancy;
  logic       host_data_valid;
  logic [3:0] tx_packet;
  logic       tx_start;
  logic       d_mode;
  logic       clear_buf;
  logic       rx_done;
  logic       tx_done;
  logic       txn_error;

  modport slave (
    input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
    input  tx_transfer_active, tx_error, buffer_occupancy, host_data_valid,
    output tx_packet, tx_start, d_mode, clear_buf, rx_done, tx_done, txn_error
  );

  modport master (
    output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
    output tx_transfer_active, tx_error, buffer_occupancy, host_data_valid,
    input  tx_packet, tx_start, d_mode, clear_buf, rx_done, tx_done, txn_error
  );

endinterface

// File: rtl/usb_timeout_cnt.sv
// rtl/usb_timeout_cnt.sv - saturating bus-turnaround timer with expiry compare
module usb_timeout_cnt #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear_i,
  input  logic        enable_i,
  output logic [15:0] count_o,
  output logic        expired_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = 16'd0;
    else if (enable_i && (count_q != 16'hFFFF))
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= 16'd0;
    else        count_q <= count_d;
  end

  assign count_o   = count_q;
  assign expired_o = (count_q >= (TIMEOUT_CYC - 16'd1));

endmodule

// File: rtl/usb_txn_ctrl.sv
// rtl/usb_txn_ctrl.sv - endpoint transaction sequencer: token/data/handshake phases and status
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000,
  parameter logic [6:0]  MAX_BYTES   = MAX_BYTES_DEFAULT
) (
  input  logic           clk,
  input  logic           n_rst,
  usb_txn_ctrl_if.slave  bus
);

  state_t      state_q, state_d;
  logic        rx_act_q, tx_act_q;
  logic        rx_fall, tx_fall;
  logic        rx_done_d, tx_done_d, host_ack;
  logic        tx_start_q, d_mode_q, clear_buf_q, rx_done_q, tx_done_q, txn_error_q;
  logic [3:0]  tx_packet_q, tx_packet_d;
  logic        txn_error_d;
  logic        timer_clr, timer_en, timer_expired;
  logic [15:0] timer_count;

  assign rx_fall = rx_act_q & ~bus.rx_transfer_active;
  assign tx_fall = tx_act_q & ~bus.tx_transfer_active;

  always_comb begin
    state_d   = state_q;
    rx_done_d = 1'b0;
    tx_done_d = 1'b0;
    host_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_packet == PID_OUT)     state_d = S_WAIT_OUT_TOK;
        else if (bus.rx_packet == PID_IN) state_d = S_WAIT_IN_TOK;
        else if (bus.rx_packet != 4'd0)   state_d = S_ERR;
      end
      S_WAIT_OUT_TOK:
        if (rx_fall) state_d = bus.rx_error ? S_ERR : S_WAIT_DATA;
      S_WAIT_DATA: begin
        // a PID landing on the expiry cycle takes priority over the timeout
        if (is_data_pid(bus.rx_packet))  state_d = S_RX_DATA;
        else if (bus.rx_packet != 4'd0)  state_d = S_ERR;
        else if (timer_expired)          state_d = S_ERR;
      end
      S_RX_DATA:
        if (!bus.rx_transfer_active)
          state_d = (bus.rx_error || (bus.buffer_occupancy > MAX_BYTES)) ? S_ERR : S_SEND_ACK;
      S_SEND_ACK:  state_d = S_WAIT_TX_HS;
      S_WAIT_TX_HS: begin
        if (bus.tx_error) state_d = S_ERR;
        else if (tx_fall) begin
          state_d   = S_IDLE;
          rx_done_d = 1'b1;
        end
      end
      S_WAIT_IN_TOK: begin
        if (rx_fall) begin
          if (bus.rx_error)             state_d = S_ERR;
          else if (!bus.host_data_valid) state_d = S_SEND_NAK;
          else                           state_d = S_SEND_DATA;
        end
      end
      S_SEND_NAK:  state_d = S_WAIT_NAK_TX;
      S_WAIT_NAK_TX: begin
        if (bus.tx_error)  state_d = S_ERR;
        else if (tx_fall)  state_d = S_IDLE;
      end
      S_SEND_DATA: state_d = S_WAIT_DATA_TX;
      S_WAIT_DATA_TX: begin
        if (bus.tx_error)  state_d = S_ERR;
        else if (tx_fall)  state_d = S_WAIT_HOST_ACK;
      end
      S_WAIT_HOST_ACK: begin
        if (bus.rx_packet == PID_ACK) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
          host_ack  = 1'b1;
        end
        else if (bus.rx_packet != 4'd0) state_d = S_ERR;
        else if (timer_expired)         state_d = S_ERR;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign timer_en  = (state_q == S_WAIT_DATA) || (state_q == S_WAIT_HOST_ACK);
  assign timer_clr = ((state_d == S_WAIT_DATA)     && (state_q != S_WAIT_DATA)) ||
                     ((state_d == S_WAIT_HOST_ACK) && (state_q != S_WAIT_HOST_ACK));

  usb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (timer_clr),
    .enable_i  (timer_en),
    .count_o   (timer_count),
    .expired_o (timer_expired)
  );

  always_comb begin
    tx_packet_d = 4'd0;
    case (state_d)
      S_SEND_ACK:  tx_packet_d = PID_ACK;
      S_SEND_NAK:  tx_packet_d = PID_NAK;
      S_SEND_DATA: tx_packet_d = PID_DATA0;
      default:     tx_packet_d = 4'd0;
    endcase
  end

  always_comb begin
    txn_error_d = txn_error_q;
    if (state_d == S_ERR)
      txn_error_d = 1'b1;
    else if ((state_q == S_IDLE) && ((bus.rx_packet == PID_OUT) || (bus.rx_packet == PID_IN)))
      txn_error_d = 1'b0;
  end

  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      rx_act_q    <= 1'b0;
      tx_act_q    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_packet_q <= 4'd0;
      d_mode_q    <= 1'b0;
      clear_buf_q <= 1'b0;
      rx_done_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      txn_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_act_q    <= bus.rx_transfer_active;
      tx_act_q    <= bus.tx_transfer_active;
      tx_start_q  <= (state_d == S_SEND_ACK) || (state_d == S_SEND_NAK) || (state_d == S_SEND_DATA);
      tx_packet_q <= tx_packet_d;
      d_mode_q    <= (state_d == S_SEND_ACK)  || (state_d == S_WAIT_TX_HS)  ||
                     (state_d == S_SEND_NAK)  || (state_d == S_WAIT_NAK_TX) ||
                     (state_d == S_SEND_DATA) || (state_d == S_WAIT_DATA_TX);
      clear_buf_q <= (state_d == S_ERR) || host_ack;
      rx_done_q   <= rx_done_d;
      tx_done_q   <= tx_done_d;
      txn_error_q <= txn_error_d;
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_packet = tx_packet_q;
  assign bus.d_mode    = d_mode_q;
  assign bus.clear_buf = clear_buf_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.txn_error = txn_error_q;

endmodule

// File: doc/usb_txn_ctrl.md
Name: usb_txn_ctrl

Overview:
Endpoint-side USB transaction sequencer. It sits between the RX packet decoder and the TX packet encoder, and it owns the shared packet data buffer.
It tracks the token/data/handshake phases of each transaction and issues the TX handshake or data packet at the right time. It enforces a bus-turnaround timeout and reports per-transaction status to the host-side register block.

Parameters:
TIMEOUT_CYC, 16'd1000, clock cycles to wait for the next packet phase before aborting
MAX_BYTES, 7'd64, maximum data payload; buffer_occupancy above this is an error

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rx_packet  in  4  PID from the RX decoder; nonzero for exactly one cycle when a PID is decoded; 0 otherwise
rx_data_ready  in  1  RX has stored a token or data byte
rx_transfer_active  in  1  RX packet in progress
rx_error  in  1  RX packet error (level, held until next sync)
tx_transfer_active  in  1  TX packet in progress
tx_error  in  1  TX aborted
buffer_occupancy  in  7  bytes currently held in the shared buffer
host_data_valid  in  1  host has loaded IN data into the buffer (level)
tx_packet  out  4  PID to send; valid while tx_start=1
tx_start  out  1  one-cycle pulse that starts the TX encoder
d_mode  out  1  1 while this block owns the bus for TX
clear_buf  out  1  one-cycle buffer flush request
rx_done  out  1  one-cycle pulse: OUT transaction completed and ACKed
tx_done  out  1  one-cycle pulse: IN transaction ACKed by the host
txn_error  out  1  sticky; cleared on the next IN or OUT token

Behaviour:
- Reset (async): state=IDLE, timer=0. All outputs 0, tx_packet=4'b0000.
- PID codes: OUT=0001, IN=1001, DATA0=0011, DATA1=1011, ACK=0010, NAK=1010. These are the same encodings as the RX decoder.
- IDLE:
  - rx_packet=OUT → WAIT_OUT_TOK. Clear txn_error.
  - rx_packet=IN → WAIT_IN_TOK. Clear txn_error.
  - Any other nonzero PID → ERR.
- WAIT_OUT_TOK: rx_transfer_active falls with rx_error=0 → WAIT_DATA, timer=0. If rx_error=1 → ERR.
- WAIT_DATA:
  - rx_packet = DATA0 or DATA1 → RX_DATA.
  - Any other nonzero PID → ERR.
  - timer reaches TIMEOUT_CYC-1 → ERR.
- RX_DATA: wait for rx_transfer_active=0.
  - rx_error=1, or buffer_occupancy > MAX_BYTES → ERR.
  - Otherwise → SEND_ACK.
- SEND_ACK: tx_start=1, tx_packet=ACK, d_mode=1 → WAIT_TX_HS.
- WAIT_TX_HS: d_mode=1. When tx_transfer_active falls: pulse rx_done, → IDLE. If tx_error=1 → ERR (no rx_done).
- WAIT_IN_TOK: when rx_transfer_active falls:
  - rx_error=1 → ERR.
  - host_data_valid=0 → SEND_NAK.
  - Otherwise → SEND_DATA.
- SEND_NAK: tx_start=1, tx_packet=NAK, d_mode=1 → WAIT_NAK_TX. When the TX finishes → IDLE, with no status pulse.
- SEND_DATA: tx_start=1, tx_packet=DATA0, d_mode=1 → WAIT_DATA_TX.
- WAIT_DATA_TX: d_mode=1. When tx_transfer_active falls → WAIT_HOST_ACK, timer=0. If tx_error=1 → ERR.
- WAIT_HOST_ACK:
  - rx_packet=ACK → pulse tx_done, pulse clear_buf, → IDLE.
  - NAK, any other PID, or timeout → ERR.
- ERR (entered from any state, single cycle): set txn_error, pulse clear_buf, d_mode=0 → IDLE.
- Timer:
  - 16-bit; increments only in WAIT_DATA and WAIT_HOST_ACK.
  - Reset to 0 on entering those states; saturates, never wraps.
- Simultaneous events:
  - A PID arriving in the same cycle as the timeout: the PID wins.
  - A falling edge of tx_transfer_active together with tx_error=1: the error wins.
- Fall detection: use registered copies of rx_transfer_active and tx_transfer_active.
- d_mode is registered and asserted from the tx_start cycle through TX completion; it is never high in IDLE.
- Reset asserted mid-transaction: all outputs go to 0 immediately (async). No pulse is generated on release.

Decomposition:
- Shared package usb_pkg holds:
  - the PID localparams (OUT, IN, DATA0, DATA1, ACK, NAK);
  - the state_t enum for this block;
  - MAX_BYTES_DEFAULT.
- One sub-module, usb_timeout_cnt: clear, enable, saturating counter, 'expired' compare against TIMEOUT_CYC.

Test Plan:
- OUT transaction: OUT token, then DATA0 with 8 bytes, occupancy=8 → tx_start with tx_packet=0010 and d_mode=1. After the TX falling edge, one rx_done pulse; txn_error=0.
- IN transaction, host_data_valid=0: IN token → tx_start with tx_packet=1010. No tx_done; back to IDLE after the TX completes.
- IN transaction, host_data_valid=1: tx_start with tx_packet=0011; host ACK 5 cycles later → tx_done and clear_buf each pulse 1 cycle.
- Timeout: OUT token then no data, TIMEOUT_CYC=20 → ERR on cycle 20; txn_error=1, clear_buf pulses, d_mode=0. The next IN token clears txn_error.
- Errors: DATA0 received with rx_error=1, and separately occupancy=65 → ERR, with no ACK sent.
- Mid-operation reset: assert n_rst=0 during WAIT_DATA_TX → d_mode=0 the same cycle. After release, IDLE with all outputs 0.
